ram_port_arbiter: RTL and testbench

//  Shares the single 256x16 data RAM between NUM_REQ requesters (ROM loader, ALU/REG file, PC unit).

---
 rtl/ram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises NUM_REQ requesters onto the single 256x16 data RAM.
// Optional: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module ram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic [NUM_REQ-1:0]               i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
    output logic [NUM_REQ-1:0]               o_ack,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_busy,
    output logic [DATA_WIDTH-1:0]            o_ram_opcode,
    output logic [DATA_WIDTH-1:0]            o_ram_operand,
    output logic [DATA_WIDTH-1:0]            o_ram_write_data,
    output logic                             o_ram_read_en,
    output logic                             o_ram_write_en,
    input  logic [DATA_WIDTH-1:0]            i_ram_read_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(16'h9100);
    localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(16'h9200);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [IDX_W-1:0]        r_winner;
    logic [IDX_W-1:0]        w_grant;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_any_req;

    assign w_any_req = |i_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_grant_hi;
    logic [IDX_W-1:0] w_grant_lo;
    logic             w_found_hi;
    logic             w_found_lo;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_grant_hi = '0;
        w_grant_lo = '0;
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i] && !w_found_hi && (IDX_W'(i) >= r_rr_ptr)) begin
                w_grant_hi = IDX_W'(i);
                w_found_hi = 1'b1;
            end
            if (i_req[i] && !w_found_lo) begin
                w_grant_lo = IDX_W'(i);
                w_found_lo = 1'b1;
            end
        end
        w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (r_state == StIdle && w_any_req) begin
            r_rr_ptr <= (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
        end
    end
`else
    logic w_found;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i] && !w_found) begin
                w_grant = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_we    = i_req_we[i];
                w_addr  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        o_ack          = '0;
        o_ram_opcode   = '0;
        o_ram_read_en  = 1'b0;
        o_ram_write_en = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) w_state_next = StAccess;
            end
            StAccess: begin
                w_state_next   = StResp;
                o_ram_opcode   = r_we ? OP_WRITE : OP_READ;
                o_ram_write_en = r_we;
                o_ram_read_en  = !r_we;
            end
            StResp: begin
                w_state_next = StIdle;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (r_winner == IDX_W'(i)) o_ack[i] = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_winner <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && w_any_req) begin
                r_winner <= w_grant;
                r_we     <= w_we;
                r_addr   <= w_addr;
                r_wdata  <= w_wdata;
            end
            if (r_state == StAccess && !r_we) begin
                r_rdata <= i_ram_read_data;
            end
        end
    end

    assign o_busy           = (r_state != StIdle);
    assign o_rdata          = r_rdata;
    assign o_ram_operand    = DATA_WIDTH'(r_addr);
    assign o_ram_write_data = r_wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: transaction-level model plus directed scenarios.
module tb_ram_port_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  req_we = '0;
    logic [23:0] req_addr = '0;
    logic [47:0] req_wdata = '0;
    logic [2:0]  ack;
    logic [15:0] rdata, opcode, operand, wdata_o, ram_rd;
    logic        busy, ren, wen;

    logic [15:0] ram [256];
    logic [15:0] m_mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req            (req),
        .i_req_we         (req_we),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_ack            (ack),
        .o_rdata          (rdata),
        .o_busy           (busy),
        .o_ram_opcode     (opcode),
        .o_ram_operand    (operand),
        .o_ram_write_data (wdata_o),
        .o_ram_read_en    (ren),
        .o_ram_write_en   (wen),
        .i_ram_read_data  (ram_rd)
    );

    // Bench-side RAM; junk on the read bus when not enabled exposes mistimed captures.
    assign ram_rd = ren ? ram[operand[7:0]] : 16'hDEAD;
    always @(posedge clk) if (wen) ram[operand[7:0]] <= wdata_o;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = (16'(i) * 16'h0101) ^ 16'h5A5A;
            m_mem[i] = (16'(i) * 16'h0101) ^ 16'h5A5A;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is accepted from idle, spends one cycle on the RAM, one cycle acking.
    int          m_age = 0;
    int          m_win = 0;
    logic        m_we = 1'b0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;
    bit          m_valid = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    int          m_rr = 0;
`endif

    function automatic int pick(input logic [2:0] r);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) if (r[(m_rr + k) % N]) return (m_rr + k) % N;
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            if (m_age == 1 && m_we) m_mem[m_addr] = m_wdata;
            m_age   = 0;
            m_rdata = '0;
            m_valid = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            m_rr = 0;
`endif
        end else if (m_age == 1) begin
            if (m_we) m_mem[m_addr] = m_wdata;
            else      m_rdata = m_mem[m_addr];
            m_age = 2;
        end else if (m_age == 2) begin
            m_age = 0;
        end else if (req != 3'b000) begin
            m_win   = pick(req);
            m_we    = req_we[m_win];
            m_addr  = req_addr[m_win*8 +: 8];
            m_wdata = req_wdata[m_win*16 +: 16];
            m_age   = 1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            m_rr = (m_win + 1) % N;
`endif
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ack", ack, (m_age == 2) ? (3'b001 << m_win) : 3'b000);
            chk("busy", busy, m_age != 0);
            chk("rdata", rdata, m_rdata);
            chk("ram_opcode", opcode, (m_age == 1) ? (m_we ? 16'h9100 : 16'h9200) : 16'h0000);
            chk("ram_read_en", ren, (m_age == 1) && !m_we);
            chk("ram_write_en", wen, (m_age == 1) && m_we);
            if (m_age == 1) begin
                chk("ram_operand", operand, {8'h00, m_addr});
                chk("ram_write_data", wdata_o, m_wdata);
            end
        end
    end

    // Per-window statistics for the literal expectations.
    int          ack_cnt [3];
    int          first_ack [3];
    int          last_ack [3];
    logic [15:0] ack_rd [3];
    int          ord, en_cnt, busy_cnt;
    logic [15:0] en_op, en_operand, en_wdata;

    task automatic set_slot(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
        req_we[i]             = we;
        req_addr[i*8 +: 8]    = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic settle();
        int n = 0;
        while (busy !== 1'b0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("settle_idle", busy, 1'b0);
    endtask

    task automatic window(input logic [2:0] raise, input bit drop_on_ack, input int cycles);
        logic [2:0] seen;
        for (int i = 0; i < 3; i++) begin
            ack_cnt[i] = 0; first_ack[i] = 0; last_ack[i] = 0; ack_rd[i] = '0;
        end
        ord = 0; en_cnt = 0; busy_cnt = 0;
        @(posedge clk); #1;
        req = req | raise;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            seen = ack;
            if (ren || wen) begin
                en_cnt++;
                en_op = opcode; en_operand = operand; en_wdata = wdata_o;
            end
            if (busy) busy_cnt++;
            for (int i = 0; i < 3; i++) begin
                if (seen[i]) begin
                    ack_cnt[i]++;
                    if (first_ack[i] == 0) first_ack[i] = c;
                    last_ack[i] = c;
                    ack_rd[i] = rdata;
                    ord = (ord << 4) | (i + 1);
                end
            end
            @(posedge clk); #1;
            if (drop_on_ack) req = req & ~seen;
        end
        req = '0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_opcode", opcode, 16'h0000);
        chk("rst_operand", operand, 16'h0000);
        chk("rst_wdata", wdata_o, 16'h0000);
        chk("rst_en", {ren, wen}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write then read back through requester 0.
        set_slot(0, 1'b1, 8'h10, 16'hBEEF);
        window(3'b001, 1'b1, 6);
        chk("t1_wr_ack_cycle", first_ack[0], 3);
        chk("t1_wr_ack_cnt", ack_cnt[0], 1);
        chk("t1_wr_en_cnt", en_cnt, 1);
        chk("t1_wr_opcode", en_op, 16'h9100);
        chk("t1_wr_operand", en_operand, 16'h0010);
        chk("t1_wr_data", en_wdata, 16'hBEEF);
        set_slot(0, 1'b0, 8'h10, 16'h0000);
        window(3'b001, 1'b1, 6);
        chk("t1_rd_ack_cycle", first_ack[0], 3);
        chk("t1_rd_data", ack_rd[0], 16'hBEEF);
        chk("t1_rd_opcode", en_op, 16'h9200);

        // Simultaneous requests, each held until its own ack.
        set_slot(0, 1'b1, 8'h30, 16'h1111); window(3'b001, 1'b1, 6);
        set_slot(1, 1'b1, 8'h31, 16'h2222); window(3'b010, 1'b1, 6);
        set_slot(2, 1'b1, 8'h32, 16'h3333); window(3'b100, 1'b1, 6);
        set_slot(0, 1'b0, 8'h30, 16'h0000);
        set_slot(1, 1'b0, 8'h31, 16'h0000);
        set_slot(2, 1'b0, 8'h32, 16'h0000);
        for (int rep = 0; rep < 2; rep++) begin
            window(3'b111, 1'b1, 12);
            chk("t2_order", ord, 32'h123);
            chk("t2_ack0_cycle", first_ack[0], 3);
            chk("t2_ack1_cycle", first_ack[1], 6);
            chk("t2_ack2_cycle", first_ack[2], 9);
            chk("t2_rd0", ack_rd[0], 16'h1111);
            chk("t2_rd1", ack_rd[1], 16'h2222);
            chk("t2_rd2", ack_rd[2], 16'h3333);
        end

        // Requester 0 held continuously alongside requester 2.
        window(3'b101, 1'b0, 12);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("t3_ack2_first", first_ack[2], 6);
        chk("t3_ack2_cnt", ack_cnt[2], 2);
        chk("t3_order", ord, 32'h1313);
`else
        chk("t3_ack2_cnt", ack_cnt[2], 0);
        chk("t3_ack0_cnt", ack_cnt[0], 4);
        chk("t3_order", ord, 32'h1111);
`endif

        // Requester inputs change during the RAM cycle; the latched values must be used.
        set_slot(1, 1'b1, 8'h20, 16'h1234);
        @(posedge clk); #1;
        req[1] = 1'b1;
        @(posedge clk); #1;
        set_slot(1, 1'b1, 8'h21, 16'hFFFF);
        @(negedge clk);
        chk("t4_wen", wen, 1'b1);
        chk("t4_operand", operand, 16'h0020);
        chk("t4_wdata", wdata_o, 16'h1234);
        @(negedge clk);
        chk("t4_ack", ack, 3'b010);
        @(posedge clk); #1;
        req = '0;
        settle();
        chk("t4_ram20", ram[8'h20], 16'h1234);
        chk("t4_ram21", ram[8'h21], 16'h7B7B);
        set_slot(1, 1'b0, 8'h20, 16'h0000);
        window(3'b010, 1'b1, 6);
        chk("t4_readback", ack_rd[1], 16'h1234);

        // Reset asserted in the response cycle of a read.
        set_slot(0, 1'b0, 8'h10, 16'h0000);
        @(posedge clk); #1;
        req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("t5_resp_ack", ack, 3'b001);
        chk("t5_resp_rdata", rdata, 16'hBEEF);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ack", ack, 3'b000);
        chk("t5_busy", busy, 1'b0);
        chk("t5_en", {ren, wen}, 2'b00);
        chk("t5_rdata", rdata, 16'h0000);
        window(3'b001, 1'b1, 6);
        chk("t5_ack_cycle", first_ack[0], 3);
        chk("t5_rd", ack_rd[0], 16'hBEEF);

        // Back-to-back reads from one held requester.
        set_slot(0, 1'b0, 8'h31, 16'h0000);
        window(3'b001, 1'b0, 12);
        chk("t6_ack_cnt", ack_cnt[0], 4);
        chk("t6_first", first_ack[0], 3);
        chk("t6_last", last_ack[0], 12);
        chk("t6_en_cnt", en_cnt, 4);
        chk("t6_busy_cnt", busy_cnt, 8);
        chk("t6_rd", ack_rd[0], 16'h2222);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
